// File: rtl/snn_iris_pkg.sv
// Shared types and default sizes for the spiking iris classifier run scheduler.
// Holds the scheduler state encoding and the default feature/count widths.
package snn_iris_pkg;

  localparam int NUM_FEATURES = 4;
  localparam int NUM_CLASSES  = 3;
  localparam int DEF_FEAT_W   = 8;
  localparam int DEF_CNT_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DECIDE,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/snn_argmax.sv
// Combinational argmax over packed per-class spike counts; ties resolve to the lowest index.
// Zero latency; all_zero flags that no class produced any spike.
module snn_argmax #(
  parameter int NUM_CLASSES = 3,
  parameter int CNT_W       = 8,
  localparam int CLS_W      = $clog2(NUM_CLASSES)
) (
  input  logic [NUM_CLASSES*CNT_W-1:0] counts,
  output logic [CLS_W-1:0]             win_idx,
  output logic                         all_zero
);

  logic [CNT_W-1:0] best;

  always_comb begin
    win_idx = '0;
    best    = counts[CNT_W-1:0];
    // strict compare keeps the earlier index on a tie
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (counts[c*CNT_W +: CNT_W] > best) begin
        best    = counts[c*CNT_W +: CNT_W];
        win_idx = CLS_W'(c);
      end
    end
    all_zero = (best == '0);
  end

endmodule

// File: rtl/snn_run_scheduler.sv
// Sequences one inference: accept sample, fill network, count output spikes, pick winner, hand off.
// Result valid PD+TS+2 cycles after accept and held until out_ready; SNN_SCHED_STATS_EN adds stat counters.
module snn_run_scheduler
  import snn_iris_pkg::*;
#(
  parameter int TIME_STEPS     = 64,
  parameter int PIPELINE_DEPTH = 8,
  parameter int NUM_CLASSES    = snn_iris_pkg::NUM_CLASSES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int FEAT_W         = DEF_FEAT_W
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_FEATURES*FEAT_W-1:0]   in_features,
  input  logic                             abort,
  output logic [NUM_FEATURES*FEAT_W-1:0]   net_features,
  output logic                             layer_reset,
  output logic                             count_enable,
  input  logic [NUM_CLASSES-1:0]           out_spikes,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(NUM_CLASSES)-1:0]   out_class,
  output logic [NUM_CLASSES*CNT_W-1:0]     out_counts,
  output logic                             no_spike,
  output logic                             busy,
  output logic [15:0]                      stat_samples,
  output logic [15:0]                      stat_stalls
);

  localparam int CLS_W  = $clog2(NUM_CLASSES);
  localparam int PH_MAX = (TIME_STEPS > PIPELINE_DEPTH) ? TIME_STEPS : PIPELINE_DEPTH;
  localparam int PH_W   = $clog2(PH_MAX);

  sched_state_e                 state_q, state_d;
  logic [PH_W-1:0]              phase_q;
  logic [NUM_CLASSES*CNT_W-1:0] cnt_q;
  logic                         accept, phase_last, abort_run, handshake;
  logic [CLS_W-1:0]             win_idx;
  logic                         all_zero;

  // layer_reset doubles as the post-reset guard so in_ready rises one edge after release
  always_comb begin
    in_ready     = (state_q == ST_IDLE) && !layer_reset;
    count_enable = (state_q == ST_RUN);
    busy         = (state_q != ST_IDLE);
    out_valid    = (state_q == ST_DONE) && !abort;
    accept       = in_valid && in_ready;
    abort_run    = abort && (state_q != ST_IDLE);
    handshake    = out_valid && out_ready;
    phase_last   = 1'b0;
    if (state_q == ST_FILL)
      phase_last = (phase_q == PH_W'(PIPELINE_DEPTH - 1));
    else if (state_q == ST_RUN)
      phase_last = (phase_q == PH_W'(TIME_STEPS - 1));

    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept)     state_d = ST_FILL;
      ST_FILL:   if (phase_last) state_d = ST_RUN;
      ST_RUN:    if (phase_last) state_d = ST_DECIDE;
      ST_DECIDE:                 state_d = ST_DONE;
      ST_DONE:   if (handshake)  state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
    if (abort_run)
      state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      layer_reset  <= 1'b1;
      net_features <= '0;
      out_class    <= '0;
      no_spike     <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_reset <= accept;
      if ((state_q == ST_FILL || state_q == ST_RUN) && state_d == state_q)
        phase_q <= phase_q + PH_W'(1);
      else
        phase_q <= '0;
      if (accept)
        net_features <= in_features;
      if (state_q == ST_DECIDE) begin
        out_class <= win_idx;
        no_spike  <= all_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (count_enable) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (out_spikes[c] && (cnt_q[c*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          cnt_q[c*CNT_W +: CNT_W] <= cnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign out_counts = cnt_q;

  snn_argmax #(
    .NUM_CLASSES (NUM_CLASSES),
    .CNT_W       (CNT_W)
  ) u_argmax (
    .counts   (cnt_q),
    .win_idx  (win_idx),
    .all_zero (all_zero)
  );

`ifdef SNN_SCHED_STATS_EN
  logic [15:0] samples_q, stalls_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samples_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (handshake)
        samples_q <= samples_q + 16'd1;
      if (state_q == ST_DONE && !out_ready && stalls_q != 16'hFFFF)
        stalls_q <= stalls_q + 16'd1;
    end
  end

  assign stat_samples = samples_q;
  assign stat_stalls  = stalls_q;
`else
  assign stat_samples = '0;
  assign stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_snn_run_scheduler.sv
// Directed bench for snn_run_scheduler: default instance plus a CNT_W=4 instance for saturation.
// Expected results are queued at issue and popped by a monitor on each result handshake.
module tb_snn_run_scheduler;

  typedef struct {
    int cls;
    int c0;
    int c1;
    int c2;
    int nos;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, abort, out_ready, sel;
  logic [31:0] in_features;
  logic [2:0]  out_spikes;

  logic        in_ready0, layer_reset0, count_enable0, out_valid0, no_spike0, busy0;
  logic [31:0] net_features0;
  logic [1:0]  out_class0;
  logic [23:0] out_counts0;
  logic [15:0] stat_samples0, stat_stalls0;

  logic        in_ready1, layer_reset1, count_enable1, out_valid1, no_spike1, busy1;
  logic [31:0] net_features1;
  logic [1:0]  out_class1;
  logic [11:0] out_counts1;
  logic [15:0] stat_samples1, stat_stalls1;

  logic        cur_in_ready, cur_layer_reset, cur_count_en, cur_valid, cur_nos, cur_busy;
  logic [31:0] cur_net;
  logic [1:0]  cur_class;
  int          cur_c0, cur_c1, cur_c2;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_samples = 0;
  int   exp_stalls  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  snn_run_scheduler u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid && !sel), .in_ready(in_ready0),
    .in_features(in_features), .abort(abort), .net_features(net_features0),
    .layer_reset(layer_reset0), .count_enable(count_enable0), .out_spikes(out_spikes),
    .out_valid(out_valid0), .out_ready(out_ready), .out_class(out_class0),
    .out_counts(out_counts0), .no_spike(no_spike0), .busy(busy0),
    .stat_samples(stat_samples0), .stat_stalls(stat_stalls0)
  );

  snn_run_scheduler #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid && sel), .in_ready(in_ready1),
    .in_features(in_features), .abort(abort), .net_features(net_features1),
    .layer_reset(layer_reset1), .count_enable(count_enable1), .out_spikes(out_spikes),
    .out_valid(out_valid1), .out_ready(out_ready), .out_class(out_class1),
    .out_counts(out_counts1), .no_spike(no_spike1), .busy(busy1),
    .stat_samples(stat_samples1), .stat_stalls(stat_stalls1)
  );

  always_comb begin
    cur_in_ready    = sel ? in_ready1     : in_ready0;
    cur_layer_reset = sel ? layer_reset1  : layer_reset0;
    cur_count_en    = sel ? count_enable1 : count_enable0;
    cur_valid       = sel ? out_valid1    : out_valid0;
    cur_nos         = sel ? no_spike1     : no_spike0;
    cur_busy        = sel ? busy1         : busy0;
    cur_net         = sel ? net_features1 : net_features0;
    cur_class       = sel ? out_class1    : out_class0;
    cur_c0          = sel ? int'(out_counts1[3:0])  : int'(out_counts0[7:0]);
    cur_c1          = sel ? int'(out_counts1[7:4])  : int'(out_counts0[15:8]);
    cur_c2          = sel ? int'(out_counts1[11:8]) : int'(out_counts0[23:16]);
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int cls, input int c0, input int c1, input int c2, input int nos);
    exp_t e;
    e.cls = cls; e.c0 = c0; e.c1 = c1; e.c2 = c2; e.nos = nos;
    return e;
  endfunction

  // RUN occupies cycles 9..72 after accept at the default depths; elsewhere drive noise
  function automatic logic [2:0] pattern(input int mode, input int k);
    if (k < 9 || k > 72) return 3'b111;
    case (mode)
      0:       return 3'b010;
      1:       return (k % 2 == 1) ? 3'b001 : 3'b100;
      2:       return 3'b000;
      3:       return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset_n && cur_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_class",    cur_class, mon_e.cls);
        chk("res_cnt0",     cur_c0,    mon_e.c0);
        chk("res_cnt1",     cur_c1,    mon_e.c1);
        chk("res_cnt2",     cur_c2,    mon_e.c2);
        chk("res_no_spike", cur_nos,   mon_e.nos);
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_layer_reset",  layer_reset0,  1);
    chk("rst_in_ready",     in_ready0,     0);
    chk("rst_busy",         busy0,         0);
    chk("rst_count_enable", count_enable0, 0);
    chk("rst_out_valid",    out_valid0,    0);
    chk("rst_net_features", net_features0, 0);
    chk("rst_out_class",    out_class0,    0);
    chk("rst_no_spike",     no_spike0,     0);
    chk("rst_counts",       out_counts0,   0);
    chk("rst_stat_samples", stat_samples0, 0);
    chk("rst_stat_stalls",  stat_stalls0,  0);
  endtask

  task automatic run_sample(input logic [31:0] f, input int mode, input int stall, input int abort_k,
                            input bit expect_out, input exp_t e, input bit chk_first);
    int guard, k, stalls_left;
    bit done, seen;
    guard = 0;
    @(posedge clk); #1;
    while (!cur_in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (chk_first) chk("accept_first_idle", guard, 0);
    if (!cur_in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    if (expect_out) exp_q.push_back(e);
    if (!sel) begin
      exp_stalls += stall;
      if (expect_out) exp_samples++;
    end
    in_features = f;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_features = ~f;
    k = 1; done = 1'b0; seen = 1'b0; stalls_left = stall;
    while (!done && k < 200) begin
      out_spikes = pattern(mode, k);
      abort      = (k == abort_k);
      out_ready  = (stalls_left == 0);
      @(negedge clk);
      if (k == 1) begin
        chk("layer_reset_c1", cur_layer_reset, 1);
        chk("busy_c1",        cur_busy,        1);
        chk("in_ready_c1",    cur_in_ready,    0);
        chk("net_features",   cur_net,         f);
      end
      if (k == 2) chk("layer_reset_c2", cur_layer_reset, 0);
      if (k == 8 || k == 73) chk("count_en_off", cur_count_en, 0);
      if (k == 9 || k == 72) chk("count_en_on",  cur_count_en, 1);
      if (cur_valid && !seen) begin
        seen = 1'b1;
        chk("done_cycle", k, 74);
      end
      if (cur_valid && !out_ready) begin
        stalls_left--;
        chk("stall_in_ready", cur_in_ready, 0);
        chk("stall_class",    cur_class,    e.cls);
        chk("stall_cnt2",     cur_c2,       e.c2);
      end
      if (abort || (cur_valid && out_ready)) done = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    if (!done) chk("run_timeout", 0, 1);
    abort      = 1'b0;
    out_ready  = 1'b0;
    out_spikes = 3'b111;
    @(negedge clk);
    chk("busy_after",        cur_busy,     0);
    chk("in_ready_after",    cur_in_ready, 1);
    chk("valid_after",       cur_valid,    0);
    chk("net_features_hold", cur_net,      f);
    if (!expect_out) chk("no_valid_on_abort", seen, 0);
    if (!sel) begin
`ifdef SNN_SCHED_STATS_EN
      chk("stat_samples", stat_samples0, exp_samples);
      chk("stat_stalls",  stat_stalls0,  exp_stalls);
`else
      chk("stat_samples", stat_samples0, 0);
      chk("stat_stalls",  stat_stalls0,  0);
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    out_spikes = 3'b111; in_features = 32'h0; sel = 1'b0;
    #12;
    chk_reset_vals();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready_before_edge", in_ready0, 0);

    run_sample(32'h0403_0201, 3, 10, -1, 1'b1, mk(2, 0, 0, 64, 0), 1'b1);
    run_sample(32'h1122_3344, 0, 0,  -1, 1'b1, mk(1, 0, 64, 0, 0), 1'b0);
    run_sample(32'hA5A5_5A5A, 1, 0,  -1, 1'b1, mk(0, 32, 0, 32, 0), 1'b0);
    run_sample(32'h0F0E_0D0C, 2, 0,  -1, 1'b1, mk(0, 0, 0, 0, 1), 1'b0);
    run_sample(32'h7777_0001, 0, 0,  28, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);
    run_sample(32'h0102_0304, 4, 0,  -1, 1'b1, mk(0, 64, 0, 0, 0), 1'b0);
    run_sample(32'hCAFE_F00D, 0, 0,  74, 1'b0, mk(0, 0, 0, 0, 0), 1'b0);

    // reset in the middle of FILL discards the run
    @(posedge clk); #1;
    in_features = 32'hDEAD_BEEF;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("busy_before_rst", busy0, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk); #1;
    chk("rst_hold_in_ready", in_ready0, 0);
    reset_n = 1'b1;
    exp_samples = 0;
    exp_stalls  = 0;
    @(negedge clk);
    chk("rel_layer_reset_before_edge", layer_reset0, 1);
    run_sample(32'h5566_7788, 0, 0, -1, 1'b1, mk(1, 0, 64, 0, 0), 1'b1);

    sel = 1'b1;
    run_sample(32'h0909_0909, 3, 0, -1, 1'b1, mk(2, 0, 0, 15, 0), 1'b0);
    sel = 1'b0;

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
